// File: rtl/button_command_decoder.sv
// button_command_decoder
// Player-input front end for the blackjack datapath. Each active-low key is
// synchronised, optionally debounced, and turned into a one-shot press pulse.
// HIT/STAND presses made during the player's turn are latched into a single
// command that the game controller consumes with a ready/ack handshake.
//
// Build option: define BUTTON_DEBOUNCE_EN to enable the per-key debounce
// counters (DEBOUNCE_CYCLES). Without it the synchronised level is accepted
// on every edge, for fast simulation or keys that are debounced in hardware.

`ifndef gameCommand
`define gameCommand logic [1:0]
`endif
`ifndef COMMAND_NONE
`define COMMAND_NONE 2'b00
`endif
`ifndef COMMAND_HIT
`define COMMAND_HIT 2'b01
`endif
`ifndef COMMAND_STAND
`define COMMAND_STAND 2'b10
`endif

module button_command_decoder #(
   parameter int NUM_KEYS        = 3,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HIT_KEY         = 0,
   parameter int STAND_KEY       = 1,
   parameter int DEAL_KEY        = 2
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_turnIndicator,
   input  logic [NUM_KEYS-1:0] i_KEY,
   input  logic                i_ack,
   output logic [NUM_KEYS-1:0] o_keyState,
   output logic [NUM_KEYS-1:0] o_keyPressed,
   output logic                o_dealButtonPushed,
   output logic                o_ready,
   output `gameCommand         o_command
);

   // Refuse to elaborate with key indices or timing that cannot work.
   if (NUM_KEYS < 3 || DEBOUNCE_CYCLES < 1 ||
       HIT_KEY < 0 || HIT_KEY >= NUM_KEYS ||
       STAND_KEY < 0 || STAND_KEY >= NUM_KEYS ||
       DEAL_KEY < 0 || DEAL_KEY >= NUM_KEYS ||
       HIT_KEY == STAND_KEY) begin : g_bad_params
      $error("button_command_decoder: invalid parameter set");
   end

   logic [NUM_KEYS-1:0] stable_vec;    // debounced raw level, 1 = released
   logic [NUM_KEYS-1:0] pressed_vec;   // registered press pulses

   for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
      logic [1:0] sync_q;
      logic       stable_q;
      logic       stable_d;
      logic       pressed_q;

      // Two-flop synchroniser; resets to the released level.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            sync_q <= 2'b11;
         end else begin
            sync_q <= {sync_q[0], i_KEY[gi]};
         end
      end

`ifdef BUTTON_DEBOUNCE_EN
      localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Accept a new level only after it differs from the stable level on
      // DEBOUNCE_CYCLES consecutive edges; any return to the stable level
      // throws the accumulated count away.
      always_comb begin
         stable_d = stable_q;
         cnt_d    = '0;
         if (sync_q[1] != stable_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable_d = sync_q[1];
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end

      // Debounce counter register.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            cnt_q <= '0;
         end else begin
            cnt_q <= cnt_d;
         end
      end
`else
      assign stable_d = sync_q[1];
`endif

      // Stable level, plus a pulse on the edge where it goes released->pressed.
      always_ff @(posedge i_clk or negedge i_rst_n) begin
         if (!i_rst_n) begin
            stable_q  <= 1'b1;
            pressed_q <= 1'b0;
         end else begin
            stable_q  <= stable_d;
            pressed_q <= stable_q & ~stable_d;
         end
      end

      assign stable_vec[gi]  = stable_q;
      assign pressed_vec[gi] = pressed_q;
   end

   assign o_keyState         = ~stable_vec;
   assign o_keyPressed       = pressed_vec;
   assign o_dealButtonPushed = pressed_vec[DEAL_KEY];

   typedef enum logic {
      IDLE = 1'b0,
      HELD = 1'b1
   } state_t;

   state_t     state_q;
   logic       ready_q;
   `gameCommand command_q;

   // Command latch: one press becomes one held command until the controller
   // acknowledges it or the turn ends. Presses while holding are dropped.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         ready_q   <= 1'b0;
         command_q <= `COMMAND_NONE;
      end else begin
         case (state_q)
            IDLE: begin
               if (i_turnIndicator && pressed_vec[STAND_KEY]) begin
                  state_q   <= HELD;
                  ready_q   <= 1'b1;
                  command_q <= `COMMAND_STAND;
               end else if (i_turnIndicator && pressed_vec[HIT_KEY]) begin
                  state_q   <= HELD;
                  ready_q   <= 1'b1;
                  command_q <= `COMMAND_HIT;
               end
            end
            HELD: begin
               if (i_ack || !i_turnIndicator) begin
                  state_q   <= IDLE;
                  ready_q   <= 1'b0;
                  command_q <= `COMMAND_NONE;
               end
            end
            default: begin
               state_q   <= IDLE;
               ready_q   <= 1'b0;
               command_q <= `COMMAND_NONE;
            end
         endcase
      end
   end

   assign o_ready   = ready_q;
   assign o_command = command_q;

endmodule

// File: tb/tb_button_command_decoder.sv
// Self-checking bench for button_command_decoder. A history-window reference
// model predicts every output each cycle; scenario tasks add directed timing
// checks on top. Works with BUTTON_DEBOUNCE_EN defined or undefined.
module tb_button_command_decoder;

   localparam int NK    = 3;
   localparam int DEB   = 4;
   localparam int HIT   = 0;
   localparam int STAND = 1;
   localparam int DEAL  = 2;
`ifdef BUTTON_DEBOUNCE_EN
   localparam int D_EFF = DEB;
`else
   localparam int D_EFF = 1;
`endif
   localparam logic [1:0] C_NONE  = 2'd0;
   localparam logic [1:0] C_HIT   = 2'd1;
   localparam logic [1:0] C_STAND = 2'd2;

   logic          i_clk = 1'b0;
   logic          i_rst_n;
   logic          i_turnIndicator;
   logic [NK-1:0] i_KEY;
   logic          i_ack;
   logic [NK-1:0] o_keyState;
   logic [NK-1:0] o_keyPressed;
   logic          o_dealButtonPushed;
   logic          o_ready;
   logic [1:0]    o_command;

   button_command_decoder #(
      .NUM_KEYS(NK), .DEBOUNCE_CYCLES(DEB),
      .HIT_KEY(HIT), .STAND_KEY(STAND), .DEAL_KEY(DEAL)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_turnIndicator(i_turnIndicator),
      .i_KEY(i_KEY), .i_ack(i_ack), .o_keyState(o_keyState),
      .o_keyPressed(o_keyPressed), .o_dealButtonPushed(o_dealButtonPushed),
      .o_ready(o_ready), .o_command(o_command)
   );

   always #5 i_clk = ~i_clk;

   int errors = 0;
   int checks = 0;

   wire [2*NK+3:0] dut_outs = {o_keyState, o_keyPressed, o_dealButtonPushed, o_ready, o_command};

   // ---------------- reference model ----------------
   // A key's level is accepted once the D_EFF most recent samples that have
   // made it through the two-flop synchroniser all disagree with the
   // accepted level. Samples from before reset count as released.
   bit         hist[NK][$];
   bit         m_stable[NK];
   bit         m_pressed[NK];
   bit         m_held;
   logic [1:0] m_cmd;

   function automatic void model_reset();
      for (int i = 0; i < NK; i++) begin
         hist[i].delete();
         for (int j = 0; j < D_EFF + 2; j++) hist[i].push_back(1'b1);
         m_stable[i]  = 1'b1;
         m_pressed[i] = 1'b0;
      end
      m_held = 1'b0;
      m_cmd  = C_NONE;
   endfunction

   task automatic model_edge(input logic [NK-1:0] keys, input bit turn, input bit ack);
      bit flip;
      int sz;
      if (!m_held) begin
         if (turn && m_pressed[STAND]) begin
            m_held = 1'b1; m_cmd = C_STAND;
            $display("t=%0t command STAND latched", $time);
         end else if (turn && m_pressed[HIT]) begin
            m_held = 1'b1; m_cmd = C_HIT;
            $display("t=%0t command HIT latched", $time);
         end
      end else if (ack || !turn) begin
         $display("t=%0t command %0d released (%s)", $time, m_cmd, ack ? "ack" : "turn over");
         m_held = 1'b0; m_cmd = C_NONE;
      end
      for (int i = 0; i < NK; i++) begin
         hist[i].push_back(keys[i]);
         if (hist[i].size() > D_EFF + 3) void'(hist[i].pop_front());
         sz   = hist[i].size();
         flip = 1'b1;
         for (int j = sz - 2 - D_EFF; j <= sz - 3; j++)
            if (hist[i][j] == m_stable[i]) flip = 1'b0;
         m_pressed[i] = flip && m_stable[i];
         if (flip) m_stable[i] = ~m_stable[i];
      end
   endtask

   function automatic logic [2*NK+3:0] model_outputs();
      logic [NK-1:0] ks, kp;
      for (int i = 0; i < NK; i++) begin
         ks[i] = ~m_stable[i];
         kp[i] = m_pressed[i];
      end
      return {ks, kp, m_pressed[DEAL], m_held, m_held ? m_cmd : C_NONE};
   endfunction

   // One clock: drive after a falling edge, advance the model on the rising
   // edge, return at the next falling edge ready for sampling.
   task automatic step(input logic [NK-1:0] keys, input bit turn, input bit ack);
      i_KEY = keys; i_turnIndicator = turn; i_ack = ack;
      @(posedge i_clk);
      model_edge(keys, turn, ack);
      @(negedge i_clk);
   endtask

   task automatic release_all(input string tag);
      for (int e = 0; e < D_EFF + 4; e++) begin
         step('1, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL %s_release e=%0d outputs got=%b want=%b", tag, e, dut_outs, model_outputs());
         end
      end
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      i_rst_n = 1'b0; i_KEY = '1; i_turnIndicator = 1'b0; i_ack = 1'b0;
      repeat (2) @(negedge i_clk);
      checks++;
      if (dut_outs !== '0) begin
         errors++;
         $display("FAIL reset_values got=%b want=%b", dut_outs, {(2*NK+4){1'b0}});
      end
      i_rst_n = 1'b1;
      model_reset();
      release_all("reset");
   endtask

   task automatic test_hit_latency();
      int first_kp = -1, first_rdy = -1;
      for (int e = 0; e < D_EFF + 6; e++) begin
         step(3'b110, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL hit e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
         if (o_keyPressed[HIT] && first_kp < 0) first_kp = e;
         if (o_ready && first_rdy < 0) first_rdy = e;
      end
      checks++;
      if (first_kp != D_EFF + 1) begin
         errors++; $display("FAIL hit_press_edge got=%0d want=%0d", first_kp, D_EFF + 1);
      end
      checks++;
      if (first_rdy != D_EFF + 2) begin
         errors++; $display("FAIL hit_ready_edge got=%0d want=%0d", first_rdy, D_EFF + 2);
      end
      checks++;
      if (o_ready !== 1'b1 || o_command !== C_HIT) begin
         errors++; $display("FAIL hit_held got ready=%b cmd=%0d want ready=1 cmd=%0d", o_ready, o_command, C_HIT);
      end
      step(3'b110, 1'b1, 1'b1);
      checks++;
      if (o_ready !== 1'b0 || o_command !== C_NONE) begin
         errors++; $display("FAIL hit_ack got ready=%b cmd=%0d want ready=0 cmd=%0d", o_ready, o_command, C_NONE);
      end
      release_all("hit");
   endtask

   task automatic test_bounce();
      int pulses = 0, last = -1;
      bit saw_hit = 0;
`ifdef BUTTON_DEBOUNCE_EN
      int exp_pulses = 1;
`else
      int exp_pulses = 2;
`endif
      for (int e = 0; e < D_EFF + 11; e++) begin
         step((e == 3) ? 3'b111 : 3'b101, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL bounce e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
         if (o_keyPressed[STAND]) begin pulses++; last = e; end
         if (o_command === C_HIT) saw_hit = 1;
      end
      checks++;
      if (pulses != exp_pulses) begin
         errors++; $display("FAIL bounce_pulses got=%0d want=%0d", pulses, exp_pulses);
      end
      checks++;
      if (last != 4 + D_EFF + 1) begin
         errors++; $display("FAIL bounce_last_pulse got=%0d want=%0d", last, 4 + D_EFF + 1);
      end
      checks++;
      if (saw_hit || o_command !== C_STAND) begin
         errors++; $display("FAIL bounce_cmd got cmd=%0d hit_seen=%0d want cmd=%0d hit_seen=0", o_command, saw_hit, C_STAND);
      end
      step(3'b101, 1'b1, 1'b1);
      release_all("bounce");
   endtask

   task automatic test_simultaneous();
      int first_rdy = -1;
      logic [1:0] cmd_at = 'x;
      for (int e = 0; e < D_EFF + 5; e++) begin
         step(3'b100, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL simul e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
         if (o_ready && first_rdy < 0) begin first_rdy = e; cmd_at = o_command; end
      end
      checks++;
      if (first_rdy != D_EFF + 2 || cmd_at !== C_STAND) begin
         errors++; $display("FAIL simul_stand got edge=%0d cmd=%0d want edge=%0d cmd=%0d", first_rdy, cmd_at, D_EFF + 2, C_STAND);
      end
      step(3'b100, 1'b1, 1'b1);
      release_all("simul");
   endtask

   task automatic test_not_turn();
      int deals = 0;
      bit rdy = 0;
      for (int e = 0; e < D_EFF + 6; e++) begin
         step(3'b010, 1'b0, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL noturn e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
         if (o_dealButtonPushed) deals++;
         if (o_ready) rdy = 1;
      end
      checks++;
      if (deals != 1 || rdy) begin
         errors++; $display("FAIL noturn_deal got deals=%0d ready_seen=%0d want deals=1 ready_seen=0", deals, rdy);
      end
      release_all("noturn");
   endtask

   task automatic test_held_cancel();
      bit rdy = 0;
      for (int e = 0; e < D_EFF + 3; e++) step(3'b110, 1'b1, 1'b0);
      for (int e = 0; e < D_EFF + 3; e++) begin
         step(3'b100, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL held e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
      end
      checks++;
      if (o_ready !== 1'b1 || o_command !== C_HIT) begin
         errors++; $display("FAIL held_keep got ready=%b cmd=%0d want ready=1 cmd=%0d", o_ready, o_command, C_HIT);
      end
      step(3'b100, 1'b0, 1'b0);
      checks++;
      if (o_ready !== 1'b0 || o_command !== C_NONE) begin
         errors++; $display("FAIL held_cancel got ready=%b cmd=%0d want ready=0 cmd=%0d", o_ready, o_command, C_NONE);
      end
      for (int e = 0; e < D_EFF + 3; e++) begin
         step(3'b100, 1'b1, 1'b0);
         if (o_ready) rdy = 1;
      end
      checks++;
      if (rdy) begin
         errors++; $display("FAIL held_dropped got ready_seen=1 want ready_seen=0");
      end
      release_all("held");
   endtask

   task automatic test_reset_mid();
      int first_kp = -1;
      for (int e = 0; e < 2; e++) step(3'b110, 1'b1, 1'b0);
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if (dut_outs !== '0) begin
         errors++; $display("FAIL rst_mid_debounce got=%b want=0", dut_outs);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      model_reset();
      for (int e = 0; e < D_EFF + 5; e++) begin
         step(3'b110, 1'b1, 1'b0);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL rstmid e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
         if (o_keyPressed[HIT] && first_kp < 0) first_kp = e;
      end
      checks++;
      if (first_kp != D_EFF + 1 || o_ready !== 1'b1) begin
         errors++; $display("FAIL rst_fresh_press got edge=%0d ready=%b want edge=%0d ready=1", first_kp, o_ready, D_EFF + 1);
      end
      #2 i_rst_n = 1'b0;
      #1;
      checks++;
      if (dut_outs !== '0) begin
         errors++; $display("FAIL rst_in_held got=%b want=0", dut_outs);
      end
      @(negedge i_clk);
      i_rst_n = 1'b1;
      model_reset();
      release_all("rstmid");
   endtask

   task automatic test_random();
      logic [NK-1:0] keys = '1;
      bit turn = 1, ack;
      for (int e = 0; e < 800; e++) begin
         for (int i = 0; i < NK; i++)
            if ($urandom_range(0, 5) == 0) keys[i] = ~keys[i];
         if ($urandom_range(0, 19) == 0) turn = ~turn;
         ack = o_ready ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
         step(keys, turn, ack);
         checks++;
         if (dut_outs !== model_outputs()) begin
            errors++;
            $display("FAIL random e=%0d outputs got=%b want=%b", e, dut_outs, model_outputs());
         end
      end
      release_all("random");
   endtask

   initial begin
      test_reset();
      test_hit_latency();
      test_bounce();
      test_simultaneous();
      test_not_turn();
      test_held_cancel();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/button_command_decoder.md
# button_command_decoder

Parametrised player-input front end for the blackjack datapath, replacing the purely combinational key decode. Synchronises and debounces N active-low push buttons, converts debounced presses into one-shot events, and latches the player's game command in a ready/acknowledge handshake so the game controller consumes each press exactly once. Sits between the board KEY pins and the game controller FSM.

## Interface
- NUM_KEYS, 3, number of active-low buttons (>= 3)
- DEBOUNCE_CYCLES, 500000, cycles a synchronised level must hold before accepted (>= 1; 10 ms at 50 MHz)
- HIT_KEY, 0, key index issuing COMMAND_HIT
- STAND_KEY, 1, key index issuing COMMAND_STAND
- DEAL_KEY, 2, key index for deal requests
- i_clk  in  1  system clock; all state on rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_turnIndicator  in  1  high while it is this player's turn
- i_KEY  in  NUM_KEYS  raw buttons, 0 = pressed, asynchronous to i_clk
- i_ack  in  1  controller has consumed o_command
- o_keyState  out  NUM_KEYS  debounced level, 1 = pressed
- o_keyPressed  out  NUM_KEYS  one-cycle pulse per debounced press (released->pressed)
- o_dealButtonPushed  out  1  one-cycle pulse on DEAL_KEY press, independent of turn
- o_ready  out  1  valid command held on o_command
- o_command  out  `gameCommand  latched command; encoding from gameCommand.svh

## Operation
- Per key: 2-flop synchroniser, reset value 1 (released).
- Per key debounce: counter width $clog2(DEBOUNCE_CYCLES+1); stable register reset 1.
  - Edge with sync == stable: counter <= 0.
  - Edge with sync != stable: counter == DEBOUNCE_CYCLES-1 -> stable <= sync, counter <= 0; else counter++.
  - Bounce returning to stable level before terminal count discards progress.
- o_keyPressed[i] registered, high exactly the cycle after stable[i] goes 1->0. Releases produce no pulse.
- o_dealButtonPushed = o_keyPressed[DEAL_KEY].
- Command FSM, states IDLE, HELD:
  - IDLE: o_ready=0, o_command=COMMAND_NONE. If i_turnIndicator and press pulse on STAND_KEY -> latch STAND, go HELD; else if press pulse on HIT_KEY -> latch HIT, go HELD. Simultaneous STAND and HIT: STAND wins, HIT dropped. Presses when not our turn dropped. i_ack ignored.
  - HELD: o_ready=1, o_command stable. i_ack=1 -> IDLE. i_turnIndicator=0 (without ack) -> IDLE, command cancelled. New presses in HELD dropped (not queued).
- Reset (any time, including mid-debounce or HELD): all outputs and state return to reset values immediately. Key held down across reset release is seen as a fresh press after debounce.

## Timing
- Reset values: o_keyState=0, o_keyPressed=0, o_dealButtonPushed=0, o_ready=0, o_command=COMMAND_NONE, FSM=IDLE.
- Raw change first sampled at edge 0, held clean: stable flips at edge DEBOUNCE_CYCLES+1; o_keyState/o_keyPressed high after that edge; o_ready high after edge DEBOUNCE_CYCLES+2.
- Handshake: i_ack sampled while o_ready=1 -> o_ready=0, o_command=NONE after that edge. Earliest next command one cycle after return to IDLE.
- i_turnIndicator sampled synchronously; caller guarantees it is in the i_clk domain.

## Configuration
- BUTTON_DEBOUNCE_EN defined: debounce counters as above.
- Undefined: counters removed, stable <= sync each edge (DEBOUNCE_CYCLES ignored); press latency 2 edges to o_keyPressed, 3 to o_ready. Used for fast simulation and keys with hardware debounce.

## Test plan
- DEBOUNCE_CYCLES=4, turn=1: hold KEY[0]=0 from edge 0 -> o_keyPressed[0] pulse after edge 5, o_ready=1 and o_command=HIT after edge 6, held until i_ack; after ack edge o_ready=0, command NONE.
- Bounce KEY[1] low 3 cycles, high 1, low steady -> exactly one STAND pulse, timed from last falling transition; no HIT.
- KEY[0] and KEY[1] released->pressed same edge, turn=1 -> command STAND only.
- turn=0, press HIT and DEAL -> o_dealButtonPushed one pulse, o_ready stays 0.
- In HELD (HIT), press STAND, then drop turn -> o_ready=0, command NONE, STAND not issued later.
- Assert i_rst_n=0 mid-debounce and in HELD -> all outputs reset values same cycle; key held through release -> one press after DEBOUNCE_CYCLES+1 edges.
